// File: rtl/qspi_flash_pkg.sv
// Shared opcodes, status masks and FSM state set for the QSPI flash
// quad-enable init sequencer.
package qspi_flash_pkg;

   localparam logic [7:0] OP_WREN   = 8'h06;
   localparam logic [7:0] OP_WRSR2  = 8'h31;
   localparam logic [7:0] OP_RDSR1  = 8'h05;
   localparam logic [7:0] OP_RDSR2  = 8'h35;
   localparam logic [7:0] QE_MASK   = 8'h02;
   localparam logic [7:0] BUSY_MASK = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP,
      ST_WRSR2,
      ST_POLL_BUSY,
      ST_VERIFY,
      ST_DONE,
      ST_ERROR
   } state_e;

   // Opcode that opens the frame of a command state
   function automatic logic [7:0] cmd_opcode(state_e s);
      logic [7:0] op;
      unique case (s)
         ST_WRSR2:     op = OP_WRSR2;
         ST_POLL_BUSY: op = OP_RDSR1;
         ST_VERIFY:    op = OP_RDSR2;
         default:      op = OP_WREN;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/qspi_byte_shifter.sv
// One-byte SPI mode-0 shifter: drives CLOCK, shifts IO0 out MSB first,
// samples IO1 on each rising CLOCK edge; back-to-back loads keep CS low.
module qspi_byte_shifter
   import qspi_flash_pkg::*;
(
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       load,
   input  logic [7:0] tx_data,
   input  logic       tx_oe,
   input  logic       io1_in,
   output logic       active,
   output logic       sclk,
   output logic       io0_out,
   output logic       io0_oe,
   output logic       byte_done,
   output logic [7:0] rx_data
);

   logic       act_q, act_d;
   logic       clk_q, clk_d;
   logic       oe_q, oe_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;
   logic       take;

   always_comb begin
      act_d     = act_q;
      clk_d     = clk_q;
      oe_d      = oe_q;
      sh_d      = sh_q;
      rx_d      = rx_q;
      bit_d     = bit_q;
      byte_done = act_q & clk_q & (bit_q == 3'd7);
      take      = load & (~act_q | byte_done);
      if (act_q && !clk_q) begin
         clk_d = 1'b1;
         rx_d  = {rx_q[6:0], io1_in};
      end else if (act_q && clk_q) begin
         clk_d = 1'b0;
         sh_d  = {sh_q[6:0], 1'b0};
         bit_d = bit_q + 3'd1;
         if (bit_q == 3'd7) begin
            act_d = 1'b0;
            oe_d  = 1'b0;
         end
      end
      // A reload on the last falling edge continues the same CS frame
      if (take) begin
         act_d = 1'b1;
         clk_d = 1'b0;
         sh_d  = tx_data;
         oe_d  = tx_oe;
         bit_d = 3'd0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         act_q <= 1'b0;
         clk_q <= 1'b0;
         oe_q  <= 1'b0;
         sh_q  <= 8'h00;
         rx_q  <= 8'h00;
         bit_q <= 3'd0;
      end else begin
         act_q <= act_d;
         clk_q <= clk_d;
         oe_q  <= oe_d;
         sh_q  <= sh_d;
         rx_q  <= rx_d;
         bit_q <= bit_d;
      end
   end

   assign active  = act_q;
   assign sclk    = clk_q;
   assign io0_oe  = oe_q;
   assign io0_out = oe_q & sh_q[7];
   assign rx_data = rx_q;

endmodule

// File: rtl/qspi_flash_init.sv
// QSPI flash quad-enable init: WREN, WRSR2(QE), poll BUSY, then hand pins over.
// Define QSPI_INIT_VERIFY_EN to read SR2 back and check QE before DONE.
module qspi_flash_init
   import qspi_flash_pkg::*;
#(
   parameter int CS_GAP   = 4,
   parameter int MAX_POLL = 255
) (
   input  logic ACLK,
   input  logic ARESETn,
   input  logic start,
   output logic done,
   output logic error,
   output logic busy,
   output logic CS,
   output logic CLOCK,
   output logic io0_out,
   output logic io0_oe,
   input  logic io1_in,
   output logic spi_owner
);

   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [7:0] POLL_LIM = 8'(MAX_POLL);

   state_e     state_q, state_d;
   state_e     nxt_q, nxt_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] poll_q, poll_d;
   logic       byte_q, byte_d;

   logic       load;
   logic [7:0] tx_data;
   logic       tx_oe;
   logic       active;
   logic       byte_done;
   logic [7:0] rx_data;
   logic       sr_busy;
   logic [7:0] poll_inc;

   qspi_byte_shifter u_shift (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .load      (load),
      .tx_data   (tx_data),
      .tx_oe     (tx_oe),
      .io1_in    (io1_in),
      .active    (active),
      .sclk      (CLOCK),
      .io0_out   (io0_out),
      .io0_oe    (io0_oe),
      .byte_done (byte_done),
      .rx_data   (rx_data)
   );

   assign sr_busy  = |(rx_data & BUSY_MASK);
   assign poll_inc = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;

`ifdef QSPI_INIT_VERIFY_EN
   logic qe_ok;
   assign qe_ok = |(rx_data & QE_MASK);
`endif

   always_comb begin
      state_d = state_q;
      nxt_d   = nxt_q;
      gap_d   = gap_q;
      poll_d  = poll_q;
      byte_d  = byte_q;
      load    = 1'b0;
      tx_data = 8'h00;
      tx_oe   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               tx_data = OP_WREN;
               tx_oe   = 1'b1;
               state_d = ST_WREN;
            end
         end
         ST_WREN: begin
            if (byte_done) begin
               state_d = ST_GAP;
               nxt_d   = ST_WRSR2;
               gap_d   = 8'd0;
            end
         end
         ST_GAP: begin
            // Load on the last high cycle so CS stays high exactly CS_GAP
            if (gap_q == GAP_LAST) begin
               load    = 1'b1;
               tx_data = cmd_opcode(nxt_q);
               tx_oe   = 1'b1;
               state_d = nxt_q;
               byte_d  = 1'b0;
               poll_d  = 8'd0;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         ST_WRSR2: begin
            if (byte_done) begin
               if (!byte_q) begin
                  load    = 1'b1;
                  tx_data = QE_MASK;
                  tx_oe   = 1'b1;
                  byte_d  = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  nxt_d   = ST_POLL_BUSY;
                  gap_d   = 8'd0;
               end
            end
         end
         ST_POLL_BUSY: begin
            if (byte_done) begin
               if (!byte_q) begin
                  load   = 1'b1;
                  byte_d = 1'b1;
               end else if (!sr_busy) begin
`ifdef QSPI_INIT_VERIFY_EN
                  state_d = ST_GAP;
                  nxt_d   = ST_VERIFY;
                  gap_d   = 8'd0;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  poll_d = poll_inc;
                  if (poll_inc == POLL_LIM) begin
                     state_d = ST_ERROR;
                  end else begin
                     load = 1'b1;
                  end
               end
            end
         end
`ifdef QSPI_INIT_VERIFY_EN
         ST_VERIFY: begin
            if (byte_done) begin
               if (!byte_q) begin
                  load   = 1'b1;
                  byte_d = 1'b1;
               end else begin
                  state_d = qe_ok ? ST_DONE : ST_ERROR;
               end
            end
         end
`endif
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
         nxt_q   <= ST_IDLE;
         gap_q   <= 8'd0;
         poll_q  <= 8'd0;
         byte_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nxt_q   <= nxt_d;
         gap_q   <= gap_d;
         poll_q  <= poll_d;
         byte_q  <= byte_d;
      end
   end

   assign CS        = ~active;
   assign done      = (state_q == ST_DONE);
   assign error     = (state_q == ST_ERROR);
   assign busy      = ~(state_q == ST_IDLE || state_q == ST_DONE
                        || state_q == ST_ERROR);
   assign spi_owner = done;

endmodule

// File: tb/tb_qspi_flash_init.sv
// Scoreboard bench for qspi_flash_init: flash model on the pins, frame
// monitor popping expected bytes, random BUSY/SR2 responses.
module tb_qspi_flash_init;

   localparam int CS_GAP   = 4;
   localparam int MAX_POLL = 8;

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;
   logic start   = 1'b0;
   logic io1_in  = 1'b0;
   logic done, error, busy, CS, CLOCK, io0_out, io0_oe, spi_owner;

   always #5 ACLK = ~ACLK;

   qspi_flash_init #(
      .CS_GAP   (CS_GAP),
      .MAX_POLL (MAX_POLL)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .start     (start),
      .done      (done),
      .error     (error),
      .busy      (busy),
      .CS        (CS),
      .CLOCK     (CLOCK),
      .io0_out   (io0_out),
      .io0_oe    (io0_oe),
      .io1_in    (io1_in),
      .spi_owner (spi_owner)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       oe;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   vec  = 0;
   int   errs = 0;

   int         fl_busy_n = 0;
   logic [7:0] fl_sr2    = 8'h00;
   logic [7:0] fl_junk   = 8'h00;

   logic       m_prev_cs  = 1'b1;
   logic       m_prev_clk = 1'b0;
   logic       m_in_frame = 1'b0;
   logic       m_have_prev = 1'b0;
   logic       m_last_flag = 1'b0;
   logic       m_oe_first = 1'b0;
   logic       m_oe_bad   = 1'b0;
   logic [7:0] m_tx = 8'h00;
   logic [7:0] m_op = 8'h00;
   int         m_bits  = 0;
   int         m_frame = 0;
   int         m_gap   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      vec++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic oe, input logic last);
      exp_t e;
      e.data = d;
      e.oe   = oe;
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Flash responses: SR1 busy for the first fl_busy_n reads, SR2 on 35h
   function automatic logic resp_bit(input logic [7:0] op, input int idx);
      int k;
      int b;
      logic [7:0] v;
      k = idx / 8;
      b = 7 - (idx % 8);
      v = 8'h00;
      if (k > 0) begin
         if (op == 8'h05)
            v = (k <= fl_busy_n) ? (fl_junk | 8'h01) : (fl_junk & 8'hFE);
         else if (op == 8'h35 && k == 1)
            v = fl_sr2;
      end
      return v[b];
   endfunction

   task automatic pop_compare();
      exp_t e;
      if (exp_q.size() == 0) begin
         vec++;
         errs++;
         $display("FAIL unexpected_byte: got %0h, expected none", m_tx);
      end else begin
         e = exp_q.pop_front();
         check("byte_oe", m_oe_first, e.oe);
         check("byte_oe_steady", m_oe_bad, 0);
         if (e.oe) check("byte_data", m_tx, e.data);
         m_last_flag = e.last;
      end
   endtask

   always @(negedge ACLK) begin
      if (!ARESETn) begin
         m_in_frame  = 1'b0;
         m_have_prev = 1'b0;
         m_gap       = 0;
         m_bits      = 0;
         m_frame     = 0;
         m_op        = 8'h00;
         io1_in      = 1'b0;
      end else if (!CS) begin
         if (m_prev_cs) begin
            if (m_have_prev) check("cs_gap", m_gap, CS_GAP);
            m_in_frame = 1'b1;
            m_bits     = 0;
            m_op       = 8'h00;
            m_frame++;
         end
         if (CLOCK && !m_prev_clk) begin
            if (m_bits % 8 == 0) begin
               m_oe_first = io0_oe;
               m_oe_bad   = 1'b0;
            end else if (io0_oe !== m_oe_first) begin
               m_oe_bad = 1'b1;
            end
            m_tx = {m_tx[6:0], io0_out};
            m_bits++;
            if (m_bits == 8) m_op = m_tx;
            if (m_bits % 8 == 0) pop_compare();
         end
         if (!CLOCK) io1_in = resp_bit(m_op, m_bits);
      end else begin
         if (!m_prev_cs && m_in_frame) begin
            check("frame_whole_bytes", m_bits % 8, 0);
            check("frame_end_last", m_last_flag, 1);
            check("clock_low_cs_high", CLOCK, 0);
            check("oe_low_cs_high", io0_oe, 0);
            m_gap       = 0;
            m_have_prev = 1'b1;
            m_in_frame  = 1'b0;
         end
         m_gap++;
      end
      m_prev_cs  = CS;
      m_prev_clk = CLOCK;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"}, CS, 1);
      check({tag, "_clock"}, CLOCK, 0);
      check({tag, "_io0"}, io0_out, 0);
      check({tag, "_oe"}, io0_oe, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_owner"}, spi_owner, 0);
   endtask

   task automatic do_reset();
      @(posedge ACLK);
      #1;
      ARESETn = 1'b0;
      start   = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge ACLK);
      exp_q.delete();
      #1;
      ARESETn = 1'b1;
   endtask

   // Reference: command list and outcome from busy count and SR2 value
   task automatic build_expected(input int busy_n, input logic [7:0] sr2,
                                 output logic exp_done);
      int   reads;
      logic tmo;
      push(8'h06, 1'b1, 1'b1);
      push(8'h31, 1'b1, 1'b0);
      push(8'h02, 1'b1, 1'b1);
      push(8'h05, 1'b1, 1'b0);
      reads = busy_n + 1;
      tmo   = 1'b0;
      if (reads > MAX_POLL) begin
         reads = MAX_POLL;
         tmo   = 1'b1;
      end
      for (int i = 1; i <= reads; i++) push(8'h00, 1'b0, i == reads);
`ifdef QSPI_INIT_VERIFY_EN
      if (!tmo) begin
         push(8'h35, 1'b1, 1'b0);
         push(8'h00, 1'b0, 1'b1);
      end
      exp_done = !tmo && sr2[1];
`else
      exp_done = !tmo && (sr2 == sr2);
`endif
   endtask

   task automatic run_seq(input int busy_n, input logic [7:0] sr2);
      logic exp_done;
      int   len;
      fl_busy_n = busy_n;
      fl_sr2    = sr2;
      fl_junk   = 8'($urandom) & 8'hFE;
      build_expected(busy_n, sr2, exp_done);
      len = $urandom_range(1, 3);
      @(posedge ACLK);
      #1;
      start = 1'b1;
      repeat (len) @(posedge ACLK);
      #1;
      start = 1'b0;
      check("busy_running", busy, 1);
      for (int c = 0; c < 4000 && !(done || error); c++) @(negedge ACLK);
      if (!(done || error)) begin
         vec++;
         errs++;
         $display("FAIL seq_timeout: got done=%0b error=%0b, expected one set",
                  done, error);
      end
      repeat (3) @(negedge ACLK);
      check("final_done", done, exp_done);
      check("final_error", error, !exp_done);
      check("final_owner", spi_owner, exp_done);
      check("final_busy", busy, 0);
      check("final_cs", CS, 1);
      check("final_clock", CLOCK, 0);
      check("exp_drained", exp_q.size(), 0);
      start = 1'b1;
      repeat (5) @(negedge ACLK);
      check("terminal_cs", CS, 1);
      check("terminal_done", done, exp_done);
      check("terminal_error", error, !exp_done);
      start = 1'b0;
   endtask

   task automatic mid_frame_reset();
      logic d;
      logic hit;
      do_reset();
      fl_busy_n = 0;
      fl_sr2    = 8'h02;
      build_expected(0, 8'h02, d);
      @(posedge ACLK);
      #1;
      start = 1'b1;
      @(posedge ACLK);
      #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
         @(posedge ACLK);
         #1;
         if (m_frame == 2 && m_bits == 5) hit = 1'b1;
      end
      check("reached_bit5", hit, 1);
      check("pre_reset_cs", CS, 0);
      ARESETn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      do_reset();
      run_seq(1, 8'h02);
   endtask

   initial begin
      do_reset();
      run_seq(3, 8'h02);
      do_reset();
      run_seq(0, 8'h00);
      do_reset();
      run_seq(7, 8'hFF);
      do_reset();
      run_seq(8, 8'h02);
      do_reset();
      run_seq(12, 8'h02);
      mid_frame_reset();
      for (int i = 0; i < 4; i++) begin
         do_reset();
         run_seq($urandom_range(0, 10), 8'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/qspi_flash_init.md
QSPI_FLASH_INIT -- requirements
Module: qspi_flash_init

Interface
REQ-001 Parameter CS_GAP, default 4, ACLK cycles CS held high between flash commands (min 2).
REQ-002 Parameter MAX_POLL, default 255, maximum status-register reads per poll phase before error.
REQ-003 ACLK input 1: single clock, rising-edge active.
REQ-004 ARESETn input 1: asynchronous active-low reset.
REQ-005 start input 1: level; rising detection not required; sequence begins when high in IDLE.
REQ-006 done output 1: high and held once QE bit is set; cleared only by reset.
REQ-007 error output 1: high and held on poll timeout or verify mismatch; cleared only by reset.
REQ-008 busy output 1: high in every state except IDLE, DONE, ERROR.
REQ-009 CS output 1: flash chip select, active low.
REQ-010 CLOCK output 1: flash serial clock, SPI mode 0.
REQ-011 io0_out output 1: serial data to flash (IO0), MSB first.
REQ-012 io0_oe output 1: IO0 drive enable; IO1..IO3 never driven by this block.
REQ-013 io1_in input 1: serial data from flash (IO1).
REQ-014 spi_owner output 1: high after done; selects the quad read engine as owner of CS/CLOCK/IO pins in the pad mux.

Function
REQ-015 CLOCK SHALL toggle every ACLK cycle while CS low and be 0 while CS high; one bit = 2 ACLK cycles, one byte = 16 cycles.
REQ-016 io0_out SHALL change only while CLOCK low; io1_in SHALL be sampled on the ACLK edge that drives CLOCK 0->1.
REQ-017 States SHALL be IDLE, WREN, GAP, WRSR2, POLL_BUSY, VERIFY, DONE, ERROR.
REQ-018 IDLE->WREN when start=1; WREN sends 06h.
REQ-019 WREN->GAP->WRSR2; WRSR2 sends 31h then 02h (QE=1) in one CS-low frame.
REQ-020 WRSR2->GAP->POLL_BUSY; POLL_BUSY sends 05h then reads status bytes continuously under one CS-low frame until bit0 (BUSY)=0.
REQ-021 Each GAP SHALL hold CS high exactly CS_GAP cycles, then enter the next command state.
REQ-022 POLL_BUSY SHALL go to ERROR when MAX_POLL bytes are read with BUSY=1; the poll counter is 8 bits, saturating, reset on entry.
REQ-023 io0_oe SHALL be 1 during opcode/data-out bytes and 0 during read bytes and while CS high.
REQ-024 start deasserting mid-sequence SHALL NOT abort the sequence.
REQ-025 DONE and ERROR are terminal; start is ignored in both.

Reset
REQ-026 On ARESETn=0, immediately: state IDLE, CS=1, CLOCK=0, io0_out=0, io0_oe=0, done=0, error=0, busy=0, spi_owner=0, all counters 0.
REQ-027 Reset asserted mid-frame SHALL force CS high in the same cycle with no partial byte completion; the next start restarts from WREN.

Configuration
REQ-028 Macro QSPI_INIT_VERIFY_EN defined: POLL_BUSY->GAP->VERIFY; VERIFY sends 35h, reads one byte; bit1=1 -> DONE, else ERROR.
REQ-029 Macro QSPI_INIT_VERIFY_EN undefined: POLL_BUSY->DONE directly; VERIFY state unreachable and not synthesised.

Structure
REQ-030 Opcode constants (06h, 31h, 05h, 35h), QE mask 02h and the state enum SHALL live in the shared package qspi_flash_pkg.
REQ-031 One sub-module qspi_byte_shifter SHALL serialise/deserialise one byte (load, shift, byte_done) and generate CLOCK; the FSM stays in qspi_flash_init.

Verification
REQ-032 Reset, start=1 one cycle -> IO0 shows 06h in 16 cycles, CS high CS_GAP=4 cycles, then 31h,02h in 32 cycles.
REQ-033 Flash model BUSY=1 for 3 status reads then 0 -> exactly 4 status bytes read, then DONE (macro off) / VERIFY frame (macro on).
REQ-034 Macro on, SR2 returns 02h -> done=1, spi_owner=1, error=0; SR2 returns 00h -> error=1, done=0.
REQ-035 BUSY stuck 1, MAX_POLL=8 -> error=1 after 8 status bytes, CS=1, CLOCK=0.
REQ-036 ARESETn pulsed low at bit 5 of 31h byte -> CS=1 same cycle, outputs at reset values; new start -> clean 06h frame.
REQ-037 Every frame: CLOCK=0 while CS=1, and io0_out stable across each CLOCK high phase.
